// File: rtl/ifc_pkg.sv
// ---------------------------------------------------------------------------
// ifc_pkg
//   Shared definitions for the master/slave streaming link: default payload
//   width and stall period, status counter width, the master state encoding
//   and a saturating increment used by the slave's status counters.
// ---------------------------------------------------------------------------
package ifc_pkg;

    localparam int DW_DEFAULT           = 64;
    localparam int STALL_PERIOD_DEFAULT = 4;
    localparam int CNT_W                = 32;

    typedef logic [DW_DEFAULT-1:0] data_t;
    typedef logic [CNT_W-1:0]      cnt_t;

    // Master is either idle or holding a word on the link until accepted.
    typedef enum logic {
        MST_IDLE = 1'b0,
        MST_SEND = 1'b1
    } mst_state_t;

    // Status counters stick at all-ones instead of wrapping back to zero.
    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == '1) ? v : v + cnt_t'(1);
    endfunction

endpackage

// File: rtl/ifc.sv
// ---------------------------------------------------------------------------
// ifc
//   Valid/ready streaming channel between one master and one slave.
//   Ports:
//     tb_clk   - link clock, all logic on posedge
//     tb_rstn  - asynchronous active-low reset
//   Signals: valid, data (master -> slave), ready (slave -> master).
// ---------------------------------------------------------------------------
interface ifc import ifc_pkg::*; #(
    parameter int DW = DW_DEFAULT
) (
    input logic tb_clk,
    input logic tb_rstn
);

    logic          valid;
    logic [DW-1:0] data;
    logic          ready;

    modport master (
        output valid,
        output data,
        input  ready,
        input  tb_clk,
        input  tb_rstn
    );

    modport slave (
        output ready,
        input  valid,
        input  data,
        input  tb_clk,
        input  tb_rstn
    );

endinterface

// File: rtl/master.sv
// ---------------------------------------------------------------------------
// master
//   Generator: presents an incrementing word sequence (0, 1, 2, ... wrapping
//   modulo 2^DW) on the link under a valid/ready handshake. Once valid is
//   raised the word is held until accepted, even if mst_en drops.
//   Ports:
//     m       - master side of the link (valid/data out, ready in, clk/rst)
//     mst_en  - allows a new word to be presented while high
// ---------------------------------------------------------------------------
module master import ifc_pkg::*; #(
    parameter int DW = DW_DEFAULT
) (
    ifc.master   m,
    input  logic mst_en
);

    mst_state_t    state_q, state_d;
    logic [DW-1:0] data_q,  data_d;
    logic [DW-1:0] next_q,  next_d;   // value to send after the current one

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge m.tb_clk or negedge m.tb_rstn) begin
        if (!m.tb_rstn) begin
            state_q <= MST_IDLE;
            data_q  <= '0;
            next_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            next_q  <= next_d;
        end
    end

    // NOTE: every output of this block is given a default first so no
    // path through the case statement can infer a latch.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        next_d  = next_q;
        unique case (state_q)
            MST_IDLE: begin
                if (mst_en) begin
                    state_d = MST_SEND;
                    data_d  = next_q;
                end
            end
            MST_SEND: begin
                // Word stays put until ready; only a handshake moves us on.
                if (m.ready) begin
                    next_d = next_q + DW'(1);
                    if (mst_en) begin
                        data_d = next_q + DW'(1);
                    end else begin
                        state_d = MST_IDLE;
                    end
                end
            end
            default: state_d = MST_IDLE;
        endcase
    end

    assign m.valid = (state_q == MST_SEND);
    assign m.data  = data_q;

endmodule

// File: rtl/slave.sv
// ---------------------------------------------------------------------------
// slave
//   Checker: accepts words with a periodic self-imposed stall (one cycle in
//   every STALL_PERIOD, none when STALL_PERIOD is 0) plus an external stall,
//   and checks that each accepted word is the previous one plus one.
//   Ports:
//     s          - slave side of the link (ready out, valid/data in)
//     slv_stall  - forces ready low while high
//     xfer_cnt   - accepted transfers, saturating
//     err_cnt    - out-of-sequence words seen, saturating
//     last_data  - payload of the most recent accepted word
// ---------------------------------------------------------------------------
module slave import ifc_pkg::*; #(
    parameter int DW           = DW_DEFAULT,
    parameter int STALL_PERIOD = STALL_PERIOD_DEFAULT
) (
    ifc.slave             s,
    input  logic          slv_stall,
    output logic [CNT_W-1:0] xfer_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [DW-1:0] last_data
);

    localparam int SCW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

    logic [SCW-1:0] stall_cnt, stall_cnt_d;
    logic           stall_slot;
    logic           ready_q,   ready_d;
    logic [DW-1:0]  expected_q;
    logic           xfer;

    // Free-running stall counter; the ready decision made from its current
    // value takes effect one cycle later because ready is registered.
    always_comb begin
        stall_slot  = 1'b0;
        stall_cnt_d = stall_cnt;
        if (STALL_PERIOD != 0) begin
            stall_slot  = (stall_cnt == SCW'(STALL_PERIOD - 1));
            stall_cnt_d = stall_slot ? '0 : stall_cnt + SCW'(1);
        end
        ready_d = !slv_stall && !stall_slot;
    end

    assign xfer = s.valid && ready_q;

    always_ff @(posedge s.tb_clk or negedge s.tb_rstn) begin
        if (!s.tb_rstn) begin
            stall_cnt  <= '0;
            ready_q    <= 1'b0;
            expected_q <= '0;
            xfer_cnt   <= '0;
            err_cnt    <= '0;
            last_data  <= '0;
        end else begin
            stall_cnt <= stall_cnt_d;
            ready_q   <= ready_d;
            if (xfer) begin
                xfer_cnt  <= sat_inc(xfer_cnt);
                last_data <= s.data;
                if (s.data != expected_q) begin
                    err_cnt <= sat_inc(err_cnt);
                end
                // Track what was actually received so one bad word costs
                // exactly one error, not an error on every word after it.
                expected_q <= s.data + DW'(1);
            end
        end
    end

    assign s.ready = ready_q;

endmodule

// File: rtl/ifc_mst_slv_link.sv
// ---------------------------------------------------------------------------
// ifc_mst_slv_link
//   Self-checking streaming link: master generator -> ifc -> slave checker.
//   Ports:
//     tb_clk     - clock
//     tb_rstn    - asynchronous active-low reset
//     mst_en     - master may present new words while high
//     slv_stall  - forces slave ready low while high
//     xfer_cnt   - accepted transfer count (saturating)
//     err_cnt    - sequence error count (saturating)
//     last_data  - most recently accepted payload
//     busy       - master valid currently asserted
// ---------------------------------------------------------------------------
module ifc_mst_slv_link import ifc_pkg::*; #(
    parameter int DW           = DW_DEFAULT,
    parameter int STALL_PERIOD = STALL_PERIOD_DEFAULT
) (
    input  logic             tb_clk,
    input  logic             tb_rstn,
    input  logic             mst_en,
    input  logic             slv_stall,
    output logic [CNT_W-1:0] xfer_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [DW-1:0]    last_data,
    output logic             busy
);

    ifc #(.DW(DW)) link (
        .tb_clk  (tb_clk),
        .tb_rstn (tb_rstn)
    );

    master #(.DW(DW)) u_master (
        .m      (link.master),
        .mst_en (mst_en)
    );

    slave #(.DW(DW), .STALL_PERIOD(STALL_PERIOD)) u_slave (
        .s         (link.slave),
        .slv_stall (slv_stall),
        .xfer_cnt  (xfer_cnt),
        .err_cnt   (err_cnt),
        .last_data (last_data)
    );

    assign busy = link.valid;

endmodule

// File: tb/tb_ifc_mst_slv_link.sv
// ---------------------------------------------------------------------------
// tb_ifc_mst_slv_link
//   Directed bench for three link builds sharing clock, reset and controls:
//     d - defaults (DW=64, STALL_PERIOD=4)
//     n - DW=64, STALL_PERIOD=0 (back-to-back)
//     w - DW=8,  STALL_PERIOD=0 (payload wrap)
//   Expected values are hand-derived; k counts posedges since reset release
//   and outputs are sampled on the following negedge.
// ---------------------------------------------------------------------------
module tb_ifc_mst_slv_link;

    logic clk = 1'b0;
    logic rstn;
    logic mst_en;
    logic slv_stall;

    logic [31:0] d_xfer, d_err, n_xfer, n_err, w_xfer, w_err;
    logic [63:0] d_last, n_last;
    logic [7:0]  w_last;
    logic        d_busy, n_busy, w_busy;

    int total = 0;
    int bad   = 0;
    int k     = 0;

    always #5 clk = ~clk;

    ifc_mst_slv_link #(.DW(64), .STALL_PERIOD(4)) u_d (
        .tb_clk (clk), .tb_rstn (rstn), .mst_en (mst_en), .slv_stall (slv_stall),
        .xfer_cnt (d_xfer), .err_cnt (d_err), .last_data (d_last), .busy (d_busy)
    );

    ifc_mst_slv_link #(.DW(64), .STALL_PERIOD(0)) u_n (
        .tb_clk (clk), .tb_rstn (rstn), .mst_en (mst_en), .slv_stall (slv_stall),
        .xfer_cnt (n_xfer), .err_cnt (n_err), .last_data (n_last), .busy (n_busy)
    );

    ifc_mst_slv_link #(.DW(8), .STALL_PERIOD(0)) u_w (
        .tb_clk (clk), .tb_rstn (rstn), .mst_en (mst_en), .slv_stall (slv_stall),
        .xfer_cnt (w_xfer), .err_cnt (w_err), .last_data (w_last), .busy (w_busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        k++;
    endtask

    initial begin
        rstn      = 1'b0;
        mst_en    = 1'b0;
        slv_stall = 1'b0;

        // Reset held 100 ns with mst_en low: everything reads zero.
        repeat (10) @(negedge clk);
        check("rst_d_xfer", 64'(d_xfer), 0);
        check("rst_d_err",  64'(d_err),  0);
        check("rst_d_last", d_last,      0);
        check("rst_d_busy", 64'(d_busy), 0);
        check("rst_n_busy", 64'(n_busy), 0);
        check("rst_w_last", 64'(w_last), 0);

        // Out of reset with mst_en low: valid never rises.
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("idle_d_busy", 64'(d_busy), 0);
        end
        check("idle_d_xfer", 64'(d_xfer), 0);
        check("idle_n_xfer", 64'(n_xfer), 0);

        // Re-reset so the stall counter phase is known, then stream.
        rstn = 1'b0;
        @(negedge clk);
        mst_en = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        k = 0;

        while (k < 100) begin
            cycle();
            if (k == 1) begin
                check("lat_d_busy", 64'(d_busy), 1);
                check("lat_n_busy", 64'(n_busy), 1);
                check("lat_d_xfer", 64'(d_xfer), 0);
            end
            if (k >= 2 && k <= 8) begin
                check("b2b_n_xfer", 64'(n_xfer), 64'(k - 1));
                check("b2b_n_last", n_last,      64'(k - 2));
            end
            if (k == 5) begin
                check("stl_d_xfer5", 64'(d_xfer), 3);
                check("stl_d_last5", d_last,      2);
            end
            if (k == 6) begin
                check("stl_d_xfer6", 64'(d_xfer), 4);
                check("stl_d_last6", d_last,      3);
            end
        end
        check("run_d_xfer", 64'(d_xfer), 75);
        check("run_d_err",  64'(d_err),  0);
        check("run_d_last", d_last,      74);
        check("run_n_xfer", 64'(n_xfer), 99);
        check("run_n_last", n_last,      98);
        check("run_w_xfer", 64'(w_xfer), 99);
        check("run_w_last", 64'(w_last), 98);

        // External stall: valid and payload held, nothing accepted.
        slv_stall = 1'b1;
        while (k < 120) begin
            cycle();
            check("hold_d_busy", 64'(d_busy), 1);
            check("hold_d_xfer", 64'(d_xfer), 75);
        end
        check("hold_n_xfer", 64'(n_xfer), 100);
        check("hold_n_last", n_last,      99);
        check("hold_n_busy", 64'(n_busy), 1);
        check("hold_w_last", 64'(w_last), 99);

        slv_stall = 1'b0;
        cycle();  // k=121: ready re-registers
        check("rel_d_xfer121", 64'(d_xfer), 75);
        cycle();  // k=122: held word accepted once
        check("rel_d_xfer122", 64'(d_xfer), 76);
        check("rel_d_last122", d_last,      75);
        check("rel_n_xfer122", 64'(n_xfer), 101);
        check("rel_n_last122", n_last,      100);
        cycle();  // k=123: next word follows
        check("rel_d_xfer123", 64'(d_xfer), 77);
        check("rel_d_last123", d_last,      76);

        // 8-bit build wraps 255 -> 0 without a sequence error.
        while (k < 330) begin
            cycle();
            if (k == 277) check("wrap_w_last255", 64'(w_last), 255);
            if (k == 278) check("wrap_w_last0",   64'(w_last), 0);
        end
        check("long_w_xfer", 64'(w_xfer), 309);
        check("long_w_last", 64'(w_last), 52);
        check("long_w_err",  64'(w_err),  0);
        check("long_n_last", n_last,      308);
        check("long_d_xfer", 64'(d_xfer), 232);
        check("long_d_last", d_last,      231);
        check("long_d_err",  64'(d_err),  0);

        // Asynchronous reset mid-stream: outputs clear before any edge.
        rstn = 1'b0;
        #1;
        check("arst_d_busy", 64'(d_busy), 0);
        check("arst_d_xfer", 64'(d_xfer), 0);
        check("arst_d_last", d_last,      0);
        check("arst_n_xfer", 64'(n_xfer), 0);
        check("arst_w_last", 64'(w_last), 0);
        @(negedge clk);
        @(negedge clk);
        check("arst_hold_busy", 64'(d_busy), 0);
        rstn = 1'b1;
        k = 0;

        cycle();  // k=1
        check("re_d_busy", 64'(d_busy), 1);
        check("re_d_xfer", 64'(d_xfer), 0);
        cycle();  // k=2: first word after reset is 0
        check("re_d_xfer2", 64'(d_xfer), 1);
        check("re_d_last2", d_last,      0);
        check("re_d_err2",  64'(d_err),  0);
        check("re_n_last2", n_last,      0);
        check("re_n_err2",  64'(n_err),  0);

        // mst_en drop while valid: pending word completes, then idle.
        mst_en = 1'b0;
        cycle();  // k=3
        check("drop_d_busy", 64'(d_busy), 0);
        check("drop_d_xfer", 64'(d_xfer), 2);
        check("drop_d_last", d_last,      1);
        check("drop_n_busy", 64'(n_busy), 0);
        mst_en = 1'b1;
        cycle();  // k=4: word 2 presented; default build ready is low next
        check("pres_d_busy", 64'(d_busy), 1);
        mst_en = 1'b0;
        cycle();  // k=5: no retraction during the stall slot
        check("keep_d_busy", 64'(d_busy), 1);
        check("keep_d_xfer", 64'(d_xfer), 2);
        check("keep_n_busy", 64'(n_busy), 0);
        check("keep_n_xfer", 64'(n_xfer), 3);
        cycle();  // k=6: accepted, then idle
        check("done_d_busy", 64'(d_busy), 0);
        check("done_d_xfer", 64'(d_xfer), 3);
        check("done_d_last", d_last,      2);
        check("done_d_err",  64'(d_err),  0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
